// File: rtl/mm2s_stream_checker.sv
// Checks MM2S AXI4-Stream readback against an incrementing pattern, with tready
// throttled to 1 cycle in RD_DIV to model a slow downstream consumer.
module mm2s_stream_checker #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned RD_DIV = 8,
  parameter int unsigned BEATS  = 1024,
  parameter int unsigned ERR_W  = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [DATA_W-1:0]     seed,
  input  logic [DATA_W-1:0]     s_axis_tdata,
  input  logic [DATA_W/8-1:0]   s_axis_tkeep,
  input  logic                  s_axis_tlast,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [ERR_W-1:0]      err_count,
  output logic                  short_err,
  output logic                  long_err,
  output logic [31:0]           first_err_beat,
  output logic [DATA_W-1:0]     first_err_data,
  output logic [31:0]           beat_count
);

  localparam int unsigned          KEEP_W   = DATA_W / 8;
  localparam int unsigned          PACE_W   = (RD_DIV > 1) ? $clog2(RD_DIV) : 1;
  localparam logic [PACE_W-1:0]    PACE_MAX = PACE_W'(RD_DIV - 1);
  localparam logic [31:0]          LAST_IDX = 32'(BEATS - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e              r_state,      w_state_nxt;
  logic [PACE_W-1:0]   r_pace,       w_pace_nxt;
  logic                r_tready,     w_tready_nxt;
  logic                r_done,       w_done_nxt;
  logic                r_pass,       w_pass_nxt;
  logic [ERR_W-1:0]    r_err_count,  w_err_count_nxt;
  logic                r_short,      w_short_nxt;
  logic                r_long,       w_long_nxt;
  logic [31:0]         r_feb,        w_feb_nxt;
  logic [DATA_W-1:0]   r_fed,        w_fed_nxt;
  logic [31:0]         r_beat_count, w_beat_count_nxt;
  logic [DATA_W-1:0]   r_expected,   w_expected_nxt;

  logic                w_beat;
  logic                w_bad;
  logic                w_last_idx;
  logic                w_short_hit;
  logic                w_long_hit;
  logic [ERR_W-1:0]    w_err_inc;
  logic [ERR_W-1:0]    w_err_final;

  // r_tready is only ever set while in RUN, so it alone qualifies a beat.
  assign w_beat      = s_axis_tvalid & r_tready;
  assign w_bad       = (s_axis_tdata != r_expected) | (s_axis_tkeep != {KEEP_W{1'b1}});
  assign w_last_idx  = (r_beat_count == LAST_IDX);
  assign w_short_hit = s_axis_tlast & (r_beat_count < LAST_IDX);
  assign w_long_hit  = w_last_idx & ~s_axis_tlast;
  assign w_err_inc   = (r_err_count == {ERR_W{1'b1}}) ? r_err_count : r_err_count + ERR_W'(1);
  assign w_err_final = w_bad ? w_err_inc : r_err_count;

  always_comb begin
    w_state_nxt      = r_state;
    w_pace_nxt       = r_pace;
    w_tready_nxt     = 1'b0;
    w_done_nxt       = 1'b0;
    w_pass_nxt       = r_pass;
    w_err_count_nxt  = r_err_count;
    w_short_nxt      = r_short;
    w_long_nxt       = r_long;
    w_feb_nxt        = r_feb;
    w_fed_nxt        = r_fed;
    w_beat_count_nxt = r_beat_count;
    w_expected_nxt   = r_expected;

    unique case (r_state)
      StIdle, StDone: begin
        if (start) begin
          w_state_nxt      = StRun;
          w_expected_nxt   = seed;
          w_beat_count_nxt = '0;
          w_err_count_nxt  = '0;
          w_short_nxt      = 1'b0;
          w_long_nxt       = 1'b0;
          w_feb_nxt        = '0;
          w_fed_nxt        = '0;
          w_pass_nxt       = 1'b0;
          w_pace_nxt       = PACE_MAX;
          w_tready_nxt     = (PACE_MAX == '0);
        end
      end
      StRun: begin
        w_pace_nxt   = (r_pace == '0) ? PACE_MAX : r_pace - PACE_W'(1);
        // Registered ready lines up with the counter reaching 0.
        w_tready_nxt = (w_pace_nxt == '0);
        if (w_beat) begin
          w_beat_count_nxt = r_beat_count + 32'd1;
          w_expected_nxt   = r_expected + DATA_W'(1);
          if (w_bad) begin
            w_err_count_nxt = w_err_inc;
            if (r_err_count == '0) begin
              w_feb_nxt = r_beat_count;
              w_fed_nxt = s_axis_tdata;
            end
          end
          if (s_axis_tlast || w_last_idx) begin
            w_state_nxt  = StDone;
            w_tready_nxt = 1'b0;
            w_done_nxt   = 1'b1;
            w_short_nxt  = w_short_hit;
            w_long_nxt   = w_long_hit;
            w_pass_nxt   = (w_err_final == '0) & ~w_short_hit & ~w_long_hit;
          end
        end
      end
      default: begin
        w_state_nxt = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= StIdle;
      r_pace       <= PACE_MAX;
      r_tready     <= 1'b0;
      r_done       <= 1'b0;
      r_pass       <= 1'b0;
      r_err_count  <= '0;
      r_short      <= 1'b0;
      r_long       <= 1'b0;
      r_feb        <= '0;
      r_fed        <= '0;
      r_beat_count <= '0;
      r_expected   <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_pace       <= w_pace_nxt;
      r_tready     <= w_tready_nxt;
      r_done       <= w_done_nxt;
      r_pass       <= w_pass_nxt;
      r_err_count  <= w_err_count_nxt;
      r_short      <= w_short_nxt;
      r_long       <= w_long_nxt;
      r_feb        <= w_feb_nxt;
      r_fed        <= w_fed_nxt;
      r_beat_count <= w_beat_count_nxt;
      r_expected   <= w_expected_nxt;
    end
  end

  assign s_axis_tready  = r_tready;
  assign busy           = (r_state == StRun);
  assign done           = r_done;
  assign pass           = r_pass;
  assign err_count      = r_err_count;
  assign short_err      = r_short;
  assign long_err       = r_long;
  assign first_err_beat = r_feb;
  assign first_err_data = r_fed;
  assign beat_count     = r_beat_count;

endmodule
